// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: per channel a synchroniser, a counter
// debouncer and a press-classification FSM (press/release/click/long/repeat).
module button_bank #(
  parameter int               N_BTN         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               DB_CYCLES     = 500000,
  parameter int               LONG_CYCLES   = 50000000,
  parameter int               REPEAT_CYCLES = 10000000,
  parameter bit               REPEAT_EN     = 1'b1,
  parameter logic [N_BTN-1:0] INVERT        = {N_BTN{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] click,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int DB_W     = $clog2(DB_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    state_e                 state_q, state_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   click_q, click_d;
    logic                   long_q, long_d;
    logic                   rpt_q, rpt_d;
    logic                   sync_bit;
    logic                   db_done;
    logic                   rise;
    logic                   fall;

    // Synchroniser shift and debounce counter; a level change is accepted only
    // after DB_CYCLES consecutive samples disagreeing with the current level.
    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in[i] ^ INVERT[i]};
      sync_bit = sync_q[SYNC_STAGES-1];
      level_d  = level_q;
      db_cnt_d = {DB_W{1'b0}};
      db_done  = 1'b0;
      if (sync_bit != level_q) begin
        if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
          level_d = sync_bit;
          db_done = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_d = {DB_W{1'b0}};
      end
      rise = db_done & sync_bit;
      fall = db_done & ~sync_bit;
    end

    // Press classification; a release in the same cycle as a hold threshold
    // takes priority and suppresses long_press/repeat.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      click_d    = 1'b0;
      long_d     = 1'b0;
      rpt_d      = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            press_d    = 1'b1;
            hold_cnt_d = {HOLD_W{1'b0}};
            state_d    = ST_HELD;
          end else begin
            hold_cnt_d = {HOLD_W{1'b0}};
          end
        end
        ST_HELD: begin
          if (fall) begin
            release_d  = 1'b1;
            click_d    = 1'b1;
            hold_cnt_d = {HOLD_W{1'b0}};
            state_d    = ST_IDLE;
          end else if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
            long_d     = 1'b1;
            hold_cnt_d = {HOLD_W{1'b0}};
            state_d    = ST_LONG;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (fall) begin
            release_d  = 1'b1;
            hold_cnt_d = {HOLD_W{1'b0}};
            state_d    = ST_IDLE;
          end else if (REPEAT_EN != 1'b0) begin
            if (hold_cnt_q == HOLD_W'(REPEAT_CYCLES - 1)) begin
              rpt_d      = 1'b1;
              hold_cnt_d = {HOLD_W{1'b0}};
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = {HOLD_W{1'b0}};
        end
      endcase
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q     <= {SYNC_STAGES{1'b0}};
        db_cnt_q   <= {DB_W{1'b0}};
        hold_cnt_q <= {HOLD_W{1'b0}};
        state_q    <= ST_IDLE;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        click_q    <= 1'b0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        sync_q     <= sync_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        state_q    <= state_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        click_q    <= click_d;
        long_q     <= long_d;
        rpt_q      <= rpt_d;
      end
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
    assign click[i]         = click_q;
    assign long_press[i]    = long_q;
    assign repeat_pulse[i]  = rpt_q;
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: two channels, channel 1 active-low, short
// debounce/hold constants so every threshold is reached within a few dozen edges.
module tb_button_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] level, press, release_pulse, click, long_press, repeat_pulse;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  button_bank #(
    .N_BTN        (2),
    .SYNC_STAGES  (2),
    .DB_CYCLES    (4),
    .LONG_CYCLES  (20),
    .REPEAT_CYCLES(5),
    .REPEAT_EN    (1'b1),
    .INVERT       (2'b10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .click        (click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  assign obs = {level, press, release_pulse, click, long_press, repeat_pulse};

  // Pack expected {ch1,ch0} pairs in the same order as obs.
  function automatic logic [11:0] pk(input logic [1:0] l, input logic [1:0] p,
                                     input logic [1:0] r, input logic [1:0] c,
                                     input logic [1:0] lg, input logic [1:0] rp);
    return {l, p, r, c, lg, rp};
  endfunction

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 2'b10;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset_held cyc %0d: got %h want %h", e, obs, 12'h000);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL active_low_idle edge %0d: got %h want %h", e, obs, 12'h000);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] exp;
    for (int e = 1; e <= 24; e++) begin
      btn_in = {1'b1, (e <= 12) ? 1'b1 : 1'b0};
      @(negedge clk);
      exp = pk({1'b0, e >= 6 && e < 18}, {1'b0, e == 6}, {1'b0, e == 18},
               {1'b0, e == 18}, 2'b00, 2'b00);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %h want %h", e, obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    for (int e = 1; e <= 46; e++) begin
      btn_in = {1'b1, (e <= 40 && ((e - 1) % 4) != 3) ? 1'b1 : 1'b0};
      @(negedge clk);
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL bounce edge %0d: got %h want %h", e, obs, 12'h000);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [11:0] exp;
    for (int e = 1; e <= 64; e++) begin
      btn_in = {1'b1, (e <= 55) ? 1'b1 : 1'b0};
      @(negedge clk);
      exp = pk({1'b0, e >= 6 && e < 61}, {1'b0, e == 6}, {1'b0, e == 61}, 2'b00,
               {1'b0, e == 26}, {1'b0, e > 26 && e < 61 && ((e - 26) % 5) == 0});
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_hold edge %0d: got %h want %h", e, obs, exp);
      end
    end
  endtask

  task automatic test_active_low_press();
    logic [11:0] exp;
    for (int e = 1; e <= 20; e++) begin
      btn_in = {(e <= 10) ? 1'b0 : 1'b1, 1'b0};
      @(negedge clk);
      exp = pk({e >= 6 && e < 16, 1'b0}, {e == 6, 1'b0}, {e == 16, 1'b0},
               {e == 16, 1'b0}, 2'b00, 2'b00);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL active_low_press edge %0d: got %h want %h", e, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [11:0] exp;
    for (int e = 1; e <= 30; e++) begin
      btn_in = 2'b11;
      @(negedge clk);
      exp = pk({1'b0, e >= 6}, {1'b0, e == 6}, 2'b00, 2'b00, {1'b0, e == 26}, 2'b00);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pre_reset_hold edge %0d: got %h want %h", e, obs, exp);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 38; e++) begin
      btn_in = {1'b1, (e <= 30) ? 1'b1 : 1'b0};
      @(negedge clk);
      exp = pk({1'b0, e >= 6 && e < 36}, {1'b0, e == 6}, {1'b0, e == 36}, 2'b00,
               {1'b0, e == 26}, {1'b0, e == 31});
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL post_reset_hold edge %0d: got %h want %h", e, obs, exp);
      end
    end
  endtask

  task automatic test_concurrency();
    logic [11:0] exp;
    for (int e = 1; e <= 40; e++) begin
      btn_in = {(e <= 32) ? 1'b0 : 1'b1, (e <= 20) ? 1'b1 : 1'b0};
      @(negedge clk);
      exp = pk({e >= 6 && e < 38, e >= 6 && e < 26}, {e == 6, e == 6},
               {e == 38, e == 26}, {1'b0, e == 26}, {e == 26, 1'b0},
               {e == 31 || e == 36, 1'b0});
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL concurrency edge %0d: got %h want %h", e, obs, exp);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 2'b10;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_active_low_press();
    test_reset_mid_hold();
    test_concurrency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
